operand_sort_stage: RTL

Pipelined, parametrised operand sorter for the FPU add/sub/compare datapath. It accepts two unpacked operands (sign, exponent, fraction with hidden bit) under a valid/ready handshake. It decides the exchange itself, either by magnitude compare or by an explicit mode, and registers the sorted pair together with the saturated exponent difference and the effective-subtract flag. It sits between the unpack stage and the alignment shifter, and a two-entry skid buffer gives it full throughput under back-pressure.

---
 rtl/fpu_pkg.sv | 56 +++++
 rtl/operand_swap_decide.sv | 58 +++++
 rtl/operand_sort_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU datapath types: exchange modes, skid-buffer states and the
// sorted-operand record passed from the sort stage to the alignment shifter.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 24;
  localparam int DIFF_MAX = FRAC_W + 2;
  localparam int DIFF_W   = $clog2(DIFF_MAX + 1);

  typedef enum logic [1:0] {
    AUTO_MAG   = 2'd0,
    PASS       = 2'd1,
    FORCE_SWAP = 2'd2,
    AUTO_EXP   = 2'd3
  } exchange_mode_t;

  // Encoding mirrors (out_valid, skid_valid) so both flags read straight off
  // the state register.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_FULL  = 2'b10,
    BUF_SKID  = 2'b11
  } buf_state_t;

  typedef struct packed {
    logic              sign_a;
    logic [EXP_W-1:0]  exp_a;
    logic [FRAC_W-1:0] frac_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] frac_b;
    logic              exchanged;
    logic [DIFF_W-1:0] exp_diff;
    logic              eff_sub;
  } sorted_operands_t;

  // Absolute exponent difference evaluated one bit wider than the exponent,
  // then clamped: shifting further than DIFF_MAX only feeds sticky.
  function automatic logic [DIFF_W-1:0] sat_exp_diff(
    input logic [EXP_W-1:0] exp_x,
    input logic [EXP_W-1:0] exp_y
  );
    logic [EXP_W:0] diff;
    if (exp_x >= exp_y) begin
      diff = {1'b0, exp_x} - {1'b0, exp_y};
    end else begin
      diff = {1'b0, exp_y} - {1'b0, exp_x};
    end
    if (diff > (EXP_W + 1)'(DIFF_MAX)) begin
      return DIFF_W'(DIFF_MAX);
    end else begin
      return diff[DIFF_W-1:0];
    end
  endfunction

endpackage

// File: rtl/operand_swap_decide.sv
// Combinational exchange decision: picks swap by mode, routes the larger
// operand to slot a and computes the saturated exponent difference.
module operand_swap_decide
  import fpu_pkg::*;
(
  input  exchange_mode_t    i_mode,
  input  logic              i_sign_a,
  input  logic              i_sign_b,
  input  logic [EXP_W-1:0]  i_exponent_a,
  input  logic [EXP_W-1:0]  i_exponent_b,
  input  logic [FRAC_W-1:0] i_fraction_a,
  input  logic [FRAC_W-1:0] i_fraction_b,
  output sorted_operands_t  o_result
);

  logic [EXP_W+FRAC_W-1:0] w_mag_a;
  logic [EXP_W+FRAC_W-1:0] w_mag_b;
  logic                    w_swap;

  assign w_mag_a = {i_exponent_a, i_fraction_a};
  assign w_mag_b = {i_exponent_b, i_fraction_b};

  // Swap decision; equal magnitudes or exponents keep the original order.
  always_comb begin
    w_swap = 1'b0;
    case (i_mode)
      AUTO_MAG:   w_swap = (w_mag_a < w_mag_b);
      PASS:       w_swap = 1'b0;
      FORCE_SWAP: w_swap = 1'b1;
      AUTO_EXP:   w_swap = (i_exponent_a < i_exponent_b);
      default:    w_swap = 1'b0;
    endcase
  end

  // Swap mux plus difference/effective-subtract, neither of which depends on the swap.
  always_comb begin
    o_result = '0;
    if (w_swap) begin
      o_result.sign_a = i_sign_b;
      o_result.exp_a  = i_exponent_b;
      o_result.frac_a = i_fraction_b;
      o_result.sign_b = i_sign_a;
      o_result.exp_b  = i_exponent_a;
      o_result.frac_b = i_fraction_a;
    end else begin
      o_result.sign_a = i_sign_a;
      o_result.exp_a  = i_exponent_a;
      o_result.frac_a = i_fraction_a;
      o_result.sign_b = i_sign_b;
      o_result.exp_b  = i_exponent_b;
      o_result.frac_b = i_fraction_b;
    end
    o_result.exchanged = w_swap;
    o_result.exp_diff  = sat_exp_diff(i_exponent_a, i_exponent_b);
    o_result.eff_sub   = i_sign_a ^ i_sign_b;
  end

endmodule

// File: rtl/operand_sort_stage.sv
// Operand sort pipeline stage: one output register plus a one-deep skid
// entry so that in_ready is registered and throughput stays at one per cycle.
module operand_sort_stage #(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 24,
  parameter int DIFF_MAX = FRAC_W + 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic                          in_sign_a,
  input  logic                          in_sign_b,
  input  logic [EXP_W-1:0]              in_exponent_a,
  input  logic [EXP_W-1:0]              in_exponent_b,
  input  logic [FRAC_W-1:0]             in_fraction_a,
  input  logic [FRAC_W-1:0]             in_fraction_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sorted_sign_a,
  output logic                          sorted_sign_b,
  output logic [EXP_W-1:0]              sorted_exponent_a,
  output logic [EXP_W-1:0]              sorted_exponent_b,
  output logic [FRAC_W-1:0]             sorted_fraction_a,
  output logic [FRAC_W-1:0]             sorted_fraction_b,
  output logic                          out_exchanged,
  output logic [$clog2(DIFF_MAX+1)-1:0] out_exp_diff,
  output logic                          out_eff_sub
);

  import fpu_pkg::*;

  buf_state_t       r_state;
  buf_state_t       w_state_next;
  sorted_operands_t w_sorted;
  sorted_operands_t r_out;
  sorted_operands_t r_skid;
  logic             w_in_fire;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;

  // Sorting happens before the registers; the skid entry stores finished results.
  operand_swap_decide u_decide (
    .i_mode       (exchange_mode_t'(in_mode)),
    .i_sign_a     (in_sign_a),
    .i_sign_b     (in_sign_b),
    .i_exponent_a (in_exponent_a),
    .i_exponent_b (in_exponent_b),
    .i_fraction_a (in_fraction_a),
    .i_fraction_b (in_fraction_b),
    .o_result     (w_sorted)
  );

  // Both handshake flags come straight from state flops.
  assign out_valid = (r_state == BUF_FULL) || (r_state == BUF_SKID);
  assign in_ready  = (r_state != BUF_SKID);
  assign w_in_fire = in_valid && in_ready;

  // State register; reset drops both entries at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and data-path load enables.
  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_in_fire) begin
          w_load_out_in = 1'b1;
          w_state_next  = BUF_FULL;
        end else begin
          w_state_next  = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (w_in_fire && out_ready) begin
          w_load_out_in = 1'b1;
          w_state_next  = BUF_FULL;
        end else if (w_in_fire) begin
          w_load_skid   = 1'b1;
          w_state_next  = BUF_SKID;
        end else if (out_ready) begin
          w_state_next  = BUF_EMPTY;
        end else begin
          w_state_next  = BUF_FULL;
        end
      end
      BUF_SKID: begin
        if (out_ready) begin
          w_load_out_skid = 1'b1;
          w_state_next    = BUF_FULL;
        end else begin
          w_state_next    = BUF_SKID;
        end
      end
      default: begin
        w_state_next = BUF_EMPTY;
      end
    endcase
  end

  // Output register: fresh result or the drained skid entry, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (w_load_out_in) begin
      r_out <= w_sorted;
    end else if (w_load_out_skid) begin
      r_out <= r_skid;
    end else begin
      r_out <= r_out;
    end
  end

  // Skid entry captures the result that arrived while the output was stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_sorted;
    end else begin
      r_skid <= r_skid;
    end
  end

  assign sorted_sign_a     = r_out.sign_a;
  assign sorted_sign_b     = r_out.sign_b;
  assign sorted_exponent_a = r_out.exp_a;
  assign sorted_exponent_b = r_out.exp_b;
  assign sorted_fraction_a = r_out.frac_a;
  assign sorted_fraction_b = r_out.frac_b;
  assign out_exchanged     = r_out.exchanged;
  assign out_exp_diff      = r_out.exp_diff;
  assign out_eff_sub       = r_out.eff_sub;

endmodule
